// File: rtl/m_lsu_align_pkg.sv
// Shared types for the M-stage load/store alignment unit: access size codes,
// FSM state codes and the access classification produced by the lane aligner.
package m_lsu_align_pkg;

  // Access size codes as carried on req_size.
  typedef enum logic [1:0] {
    LSU_B = 2'd0,
    LSU_H = 2'd1,
    LSU_W = 2'd2,
    LSU_D = 2'd3
  } lsu_size_e;

  // Request lifecycle: accept, one or two bus beats, then hold the response.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // How a request is executed: one beat, two beats, or rejected.
  typedef enum logic [1:0] {
    ACC_ONE   = 2'd0,
    ACC_SPLIT = 2'd1,
    ACC_ERR   = 2'd2
  } lsu_acc_e;

  // Number of bytes moved by an access of the given size code.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/m_lane_align.sv
// Combinational lane aligner for one bus beat. Classifies the access,
// produces the lane-aligned beat address, byte enables and shifted store
// data for the selected beat, and extracts/extends load data. For the second
// beat of a split access the read field is assembled from the first beat's
// data (i_rdata_prev) and the current beat's data (i_rdata).
module m_lane_align
  import m_lsu_align_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b0
) (
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [1:0]          i_size,
  input  logic                i_sext,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic                i_beat,
  input  logic [DATA_W-1:0]   i_rdata,
  input  logic [DATA_W-1:0]   i_rdata_prev,
  output logic [1:0]          o_kind,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [DATA_W/8-1:0] o_be,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  logic [OFF_W-1:0]    w_off;
  logic [3:0]          w_off4;
  logic [3:0]          w_bytes;
  logic                w_illegal;
  logic                w_misaligned;
  logic                w_crosses;
  logic [ADDR_W-1:0]   w_base;
  logic [2*NB-1:0]     w_be_wide;
  logic [2*DATA_W-1:0] w_wdata_wide;
  logic [2*DATA_W-1:0] w_rdata_wide;
  logic [DATA_W-1:0]   w_field;
  logic                w_sign;

  assign w_off        = i_addr[OFF_W-1:0];
  assign w_off4       = 4'(w_off);
  assign w_bytes      = size_bytes(i_size);
  assign w_illegal    = (i_size == LSU_D) && (NB < 8);
  assign w_misaligned = |(w_off4 & (w_bytes - 4'd1));
  assign w_crosses    = ({1'b0, w_off4} + {1'b0, w_bytes}) > 5'(NB);

  // Classify the access: illegal size, misaligned without split support, or split.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    o_kind = ACC_ONE;
    if (w_illegal) begin
      o_kind = ACC_ERR;
    end else if (w_misaligned) begin
      if (!SPLIT_EN) begin
        o_kind = ACC_ERR;
      end else if (w_crosses) begin
        o_kind = ACC_SPLIT;
      end
    end
  end

  // Enables and store data are built across two lane groups; beat 1 takes the upper group.
  assign w_base       = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_be_wide    = (2*NB)'((16'd1 << w_bytes) - 16'd1) << w_off;
  assign w_wdata_wide = {{DATA_W{1'b0}}, i_wdata} << {w_off, 3'b000};

  assign o_addr  = i_beat ? (w_base + ADDR_W'(NB)) : w_base;
  assign o_be    = i_beat ? w_be_wide[2*NB-1:NB] : w_be_wide[NB-1:0];
  assign o_wdata = i_beat ? w_wdata_wide[2*DATA_W-1:DATA_W] : w_wdata_wide[DATA_W-1:0];

  // Read bytes are assembled in address order before the field is shifted down.
  assign w_rdata_wide = i_beat ? {i_rdata, i_rdata_prev} : {{DATA_W{1'b0}}, i_rdata};
  assign w_field      = DATA_W'(w_rdata_wide >> {w_off, 3'b000});

  // Keep the access's bytes and fill the rest with the sign or zero.
  always_comb begin
    w_sign  = 1'b0;
    o_rdata = '0;
    for (int k = 0; k < NB; k++) begin
      if (k == int'(w_bytes) - 1) w_sign = w_field[8*k+7];
    end
    for (int k = 0; k < NB; k++) begin
      if (k < int'(w_bytes)) o_rdata[8*k +: 8] = w_field[8*k +: 8];
      else                   o_rdata[8*k +: 8] = {8{i_sext & w_sign}};
    end
  end

endmodule

// File: rtl/m_lsu_align.sv
// M-stage load/store alignment unit. Accepts one request at a time, runs one
// bus beat (or two for a lane-group-crossing access) over a req/ack data bus
// with wait states, then holds the extended response until consumed.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN -- when defined, misaligned
// accesses are executed (split into two beats if they cross a lane group);
// otherwise any misaligned access is answered with rsp_err and no bus traffic.
module m_lsu_align
  import m_lsu_align_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_sext,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                bus_req,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB = DATA_W / 8;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_e          r_state;
  lsu_state_e          w_state_nxt;
  logic                r_we;
  logic                r_sext;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic                r_split;
  logic [DATA_W-1:0]   r_rdata_lo;
`endif

  logic                w_idle;
  logic                w_beat;
  logic                w_last_ack;
  logic [1:0]          w_kind;
  logic [ADDR_W-1:0]   w_al_addr;
  logic [1:0]          w_al_size;
  logic [DATA_W-1:0]   w_al_rdata_prev;
  logic [ADDR_W-1:0]   w_bus_addr;
  logic [NB-1:0]       w_bus_be;
  logic [DATA_W-1:0]   w_bus_wdata;
  logic [DATA_W-1:0]   w_ext;

  // While idle the aligner classifies the incoming request; afterwards it
  // works from the registered request so beat outputs stay stable.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_al_addr = w_idle ? req_addr : r_addr;
  assign w_al_size = w_idle ? req_size : r_size;
`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_beat          = (r_state == ST_BEAT1);
  assign w_al_rdata_prev = r_rdata_lo;
`else
  assign w_beat          = 1'b0;
  assign w_al_rdata_prev = '0;
`endif

  m_lane_align #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .SPLIT_EN(SPLIT_EN)
  ) u_lane_align (
    .i_addr      (w_al_addr),
    .i_size      (w_al_size),
    .i_sext      (r_sext),
    .i_wdata     (r_wdata),
    .i_beat      (w_beat),
    .i_rdata     (bus_rdata),
    .i_rdata_prev(w_al_rdata_prev),
    .o_kind      (w_kind),
    .o_addr      (w_bus_addr),
    .o_be        (w_bus_be),
    .o_wdata     (w_bus_wdata),
    .o_rdata     (w_ext)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and output decode; outputs are zero outside their owning state.
  always_comb begin
    w_state_nxt = r_state;
    w_last_ack  = 1'b0;
    req_ready   = 1'b0;
    bus_req     = 1'b0;
    bus_addr    = '0;
    bus_we      = 1'b0;
    bus_be      = '0;
    bus_wdata   = '0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = (w_kind == ACC_ERR) ? ST_RESP : ST_BEAT0;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_BEAT0, ST_BEAT1: begin
`else
      ST_BEAT0: begin
`endif
        bus_req   = 1'b1;
        bus_addr  = w_bus_addr;
        bus_we    = r_we;
        bus_be    = w_bus_be;
        bus_wdata = w_bus_wdata;
        if (bus_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (r_state == ST_BEAT0 && r_split) begin
            w_state_nxt = ST_BEAT1;
          end else begin
            w_state_nxt = ST_RESP;
            w_last_ack  = 1'b1;
          end
`else
          w_state_nxt = ST_RESP;
          w_last_ack  = 1'b1;
`endif
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = r_rsp_rdata;
        rsp_err   = r_rsp_err;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture on accept and response capture on the final beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we        <= 1'b0;
      r_sext      <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_idle && req_valid) begin
        r_we        <= req_we;
        r_sext      <= req_sext;
        r_size      <= req_size;
        r_addr      <= req_addr;
        r_wdata     <= req_wdata;
        r_rsp_rdata <= '0;
        r_rsp_err   <= (w_kind == ACC_ERR);
      end
      if (w_last_ack) r_rsp_rdata <= r_we ? '0 : w_ext;
    end
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // Split bookkeeping: remember the access needs a second beat and keep beat 0's read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_split    <= 1'b0;
      r_rdata_lo <= '0;
    end else begin
      if (w_idle && req_valid)                r_split    <= (w_kind == ACC_SPLIT);
      if (r_state == ST_BEAT0 && bus_ack)     r_rdata_lo <= bus_rdata;
    end
  end
`endif

endmodule
